sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
- Parametrised successor to the team's single-clock FIFO.
- Adds:
  - configurable almost-full/almost-empty thresholds
  - occupancy count
  - selectable standard or first-word-fall-through (FWFT) read mode
  - simultaneous read/write when full
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits between a producer and a consumer in one clock domain, as the general-purpose buffer for datapath and testbench-driven blocks.

Parameters:
- DATA_WIDTH, 8: width of each data word.
- DEPTH, 8: number of entries; power of two, >= 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; empties the FIFO.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read/pop request.
- data_out  out  DATA_WIDTH  read data.
- rd_valid  out  1  data_out holds valid read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0, data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Hence empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- Pointers are PTR_WIDTH+1 bits (PTR_WIDTH = $clog2(DEPTH)); the low bits address memory and wrap modulo DEPTH.
- count is a registered counter, updated as:
  - +1 on an accepted write only
  - -1 on an accepted read only
  - unchanged when both or neither are accepted
- full, empty, almost_full and almost_empty are combinational decodes of count; all flags are evaluated on pre-edge state.
- Read acceptance: rd_acc = rd_en & !empty.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc). When full, a simultaneous read and write both succeed and count stays DEPTH.
- When empty, a simultaneous read and write: the write is accepted, the read is rejected, and underflow sets.
- Error flags:
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & !rd_acc.
  - Both hold until reset or clear.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at the edge and rd_valid = 1 for exactly the following cycle; latency is 1 cycle from rd_en.
  - Otherwise rd_valid = 0 and data_out holds its last value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally when !empty, and 0 when empty.
  - rd_valid = !empty.
  - rd_en acts as a pop/acknowledge; the next word appears the cycle after the pop.
  - Write-to-data_out latency on an empty FIFO is 1 cycle: the word is visible the cycle after the write edge.
- clear:
  - Overrides wr_en and rd_en in the same cycle (no write or read accepted).
  - Sets pointers and count to 0 and clears overflow, underflow and rd_valid.
  - data_out holds in standard mode; in FWFT mode it shows 0 because the FIFO is empty.
- Reset mid-operation discards all contents immediately; there is no partial completion of in-flight reads.
- Data order is strictly FIFO across pointer wrap-around; MSB-differs plus low-bits-equal on the pointers must agree with count == DEPTH (assertion in RTL).

Test Plan:
- Fill/drain, FWFT=0, DEPTH=8:
  - write 0x10..0x17 -> full=1, count=8, almost_full=1 from count 6.
  - read 8 -> data_out 0x10..0x17 each one cycle after rd_en, rd_valid pulses, empty=1 after the eighth read.
- Overflow/underflow:
  - wr_en while full with rd_en=0 -> overflow=1 sticky, count stays 8, contents intact.
  - rd_en while empty -> underflow=1, data_out unchanged.
  - clear -> both flags 0.
- Simultaneous ops:
  - full plus rd_en & wr_en(0xAA) -> count stays 8, no overflow, 0xAA read out last.
  - empty plus rd_en & wr_en(0x55) -> count=1, underflow=1.
- FWFT=1:
  - write 0x3C to an empty FIFO -> next cycle data_out=0x3C, rd_valid=1 with no rd_en.
  - pop -> rd_valid=0, data_out=0.
- Wrap-around: 20 interleaved write/read pairs with an incrementing pattern -> no data loss or reordering; count oscillates 0..3 as driven.
- Async reset mid-burst:
  - assert rst_n low between edges with count=5 -> outputs return to reset values immediately.
  - release reset -> first write/read returns the new data only.

Source files
------------

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer bundle for sync_fifo_flex: write side, read side, status and error flags.
// The master drives requests and data_in; the slave (the FIFO) drives everything else.
interface sync_fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_WIDTH-1:0]  count;
    logic                  overflow;
    logic                  underflow;

    // A request is taken at the rising edge where it is high; wr_en is accepted when
    // !full or a read is accepted in the same cycle, rd_en when !empty; clear wins over both.
    modport master (
        output clear, wr_en, data_in, rd_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, data_in, rd_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with thresholds, occupancy count, sticky error flags, flush and
// a build-time choice between a registered read port and first-word-fall-through.
module sync_fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input logic            clk,
    input logic            rst_n,
    sync_fifo_flex_if.slave bus
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_THRESH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   PTR_ONE = (PTR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  full, empty;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign rd_word = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];

    always_comb begin
        rd_acc      = !bus.clear && bus.rd_en && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
        wr_acc      = !bus.clear && bus.wr_en && (!full || rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        dout_d      = dout_q;
        rd_valid_d  = rd_acc;
        overflow_d  = overflow_q  || (bus.wr_en && !wr_acc);
        underflow_d = underflow_q || (bus.rd_en && !rd_acc);

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = rd_word;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (bus.clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rd_valid_d  = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dout_q      <= dout_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= bus.data_in;
    end

    assign bus.data_out     = (FWFT != 0) ? (empty ? '0 : rd_word) : dout_q;
    assign bus.rd_valid     = (FWFT != 0) ? !empty : rd_valid_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // The extra pointer bit and the counter are independent views of occupancy.
    logic ptr_full, ptr_empty;
    assign ptr_full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) &&
                       (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]);
    assign ptr_empty = (wr_ptr_q == rd_ptr_q);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (ptr_full == full);
            assert (ptr_empty == empty);
        end
    end
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: one standard-mode and one FWFT instance on a shared clock/reset.
module tb_sync_fifo_flex;
  localparam int DW = 8;
  localparam int D  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(D)) a_if ();
  sync_fifo_flex_if #(.DATA_WIDTH(DW), .DEPTH(D)) b_if ();

  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;
  int m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_if.clear = 0; a_if.wr_en = 0; a_if.rd_en = 0; a_if.data_in = '0;
    b_if.clear = 0; b_if.wr_en = 0; b_if.rd_en = 0; b_if.data_in = '0;

    // reset state
    #12;
    chk("rst_count", 32'(a_if.count), 0);
    chk("rst_empty", 32'(a_if.empty), 1);
    chk("rst_full", 32'(a_if.full), 0);
    chk("rst_ae", 32'(a_if.almost_empty), 1);
    chk("rst_af", 32'(a_if.almost_full), 0);
    chk("rst_dout", 32'(a_if.data_out), 0);
    chk("rst_rvalid", 32'(a_if.rd_valid), 0);
    chk("rst_ovf", 32'(a_if.overflow), 0);
    chk("rst_unf", 32'(a_if.underflow), 0);
    chk("rst_b_dout", 32'(b_if.data_out), 0);
    chk("rst_b_rvalid", 32'(b_if.rd_valid), 0);
    rst_n = 1'b1;

    // fill 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      a_if.wr_en = 1; a_if.data_in = DW'(16 + i);
      tick();
      chk($sformatf("fill_count%0d", i), 32'(a_if.count), 32'(i + 1));
      chk($sformatf("fill_af%0d", i), 32'(a_if.almost_full), (i + 1 >= 6) ? 1 : 0);
      chk($sformatf("fill_ae%0d", i), 32'(a_if.almost_empty), (i + 1 <= 2) ? 1 : 0);
    end
    a_if.wr_en = 0;
    chk("fill_full", 32'(a_if.full), 1);
    chk("fill_empty", 32'(a_if.empty), 0);

    // overflow while full, sticky
    a_if.wr_en = 1; a_if.data_in = 8'hEE;
    tick();
    a_if.wr_en = 0;
    chk("ovf_set", 32'(a_if.overflow), 1);
    chk("ovf_count", 32'(a_if.count), 8);
    tick();
    chk("ovf_sticky", 32'(a_if.overflow), 1);

    // drain
    for (int i = 0; i < 8; i++) begin
      a_if.rd_en = 1;
      tick();
      chk($sformatf("drain_data%0d", i), 32'(a_if.data_out), 32'(16 + i));
      chk($sformatf("drain_rv%0d", i), 32'(a_if.rd_valid), 1);
      chk($sformatf("drain_count%0d", i), 32'(a_if.count), 32'(7 - i));
    end
    a_if.rd_en = 0;
    chk("drain_empty", 32'(a_if.empty), 1);
    tick();
    chk("idle_rv", 32'(a_if.rd_valid), 0);
    chk("idle_hold", 32'(a_if.data_out), 32'h17);

    // underflow
    a_if.rd_en = 1;
    tick();
    a_if.rd_en = 0;
    chk("unf_set", 32'(a_if.underflow), 1);
    chk("unf_rv", 32'(a_if.rd_valid), 0);
    chk("unf_hold", 32'(a_if.data_out), 32'h17);

    // clear resets flags
    a_if.clear = 1;
    tick();
    a_if.clear = 0;
    chk("clr_ovf", 32'(a_if.overflow), 0);
    chk("clr_unf", 32'(a_if.underflow), 0);
    chk("clr_count", 32'(a_if.count), 0);

    // simultaneous read/write while full
    for (int i = 0; i < 8; i++) begin
      a_if.wr_en = 1; a_if.data_in = DW'(32 + i);
      tick();
    end
    chk("sim_full", 32'(a_if.full), 1);
    a_if.rd_en = 1; a_if.wr_en = 1; a_if.data_in = 8'hAA;
    tick();
    a_if.wr_en = 0;
    chk("sim_count", 32'(a_if.count), 8);
    chk("sim_ovf", 32'(a_if.overflow), 0);
    chk("sim_data", 32'(a_if.data_out), 32'h20);
    for (int i = 0; i < 8; i++) begin
      tick();
      e = (i < 7) ? DW'(33 + i) : 8'hAA;
      chk($sformatf("sim_drain%0d", i), 32'(a_if.data_out), 32'(e));
    end
    a_if.rd_en = 0;
    chk("sim_empty", 32'(a_if.empty), 1);

    // simultaneous read/write while empty
    a_if.rd_en = 1; a_if.wr_en = 1; a_if.data_in = 8'h55;
    tick();
    a_if.rd_en = 0; a_if.wr_en = 0;
    chk("se_count", 32'(a_if.count), 1);
    chk("se_unf", 32'(a_if.underflow), 1);
    chk("se_rv", 32'(a_if.rd_valid), 0);
    a_if.rd_en = 1;
    tick();
    a_if.rd_en = 0;
    chk("se_data", 32'(a_if.data_out), 32'h55);
    chk("se_rv2", 32'(a_if.rd_valid), 1);
    a_if.clear = 1;
    tick();
    a_if.clear = 0;

    // wrap-around with scoreboard, count 0..3
    m = 0;
    for (int i = 0; i < 20; i++) begin
      a_if.wr_en = 1; a_if.data_in = DW'(64 + i);
      exp_q.push_back(DW'(64 + i));
      tick();
      a_if.wr_en = 0;
      m++;
      chk($sformatf("wrap_wcount%0d", i), 32'(a_if.count), 32'(m));
      if (i % 3 == 2 || i == 19) begin
        for (int k = 0; k < m + k; k++) begin
          if (exp_q.size() == 0) break;
          a_if.rd_en = 1;
          tick();
          e = exp_q.pop_front();
          m--;
          chk($sformatf("wrap_data%0d_%0d", i, k), 32'(a_if.data_out), 32'(e));
          chk($sformatf("wrap_rcount%0d_%0d", i, k), 32'(a_if.count), 32'(m));
        end
        a_if.rd_en = 0;
      end
    end
    chk("wrap_empty", 32'(a_if.empty), 1);

    // FWFT instance
    chk("fw_idle_dout", 32'(b_if.data_out), 0);
    b_if.wr_en = 1; b_if.data_in = 8'h3C;
    tick();
    b_if.wr_en = 0;
    chk("fw_dout", 32'(b_if.data_out), 32'h3C);
    chk("fw_rv", 32'(b_if.rd_valid), 1);
    b_if.rd_en = 1;
    tick();
    b_if.rd_en = 0;
    chk("fw_pop_rv", 32'(b_if.rd_valid), 0);
    chk("fw_pop_dout", 32'(b_if.data_out), 0);
    b_if.wr_en = 1; b_if.data_in = 8'h11;
    tick();
    b_if.data_in = 8'h22;
    tick();
    b_if.wr_en = 0;
    chk("fw_first", 32'(b_if.data_out), 32'h11);
    b_if.rd_en = 1;
    tick();
    b_if.rd_en = 0;
    chk("fw_second", 32'(b_if.data_out), 32'h22);
    chk("fw_count", 32'(b_if.count), 1);
    b_if.rd_en = 1;
    tick();
    b_if.rd_en = 0;
    chk("fw_drained", 32'(b_if.data_out), 0);
    b_if.wr_en = 1; b_if.data_in = 8'h99;
    tick();
    b_if.wr_en = 0;
    chk("fw_pre_clr", 32'(b_if.data_out), 32'h99);
    b_if.clear = 1;
    tick();
    b_if.clear = 0;
    chk("fw_clr_dout", 32'(b_if.data_out), 0);
    chk("fw_clr_rv", 32'(b_if.rd_valid), 0);

    // async reset mid-burst with count=5
    for (int i = 0; i < 6; i++) begin
      a_if.wr_en = 1; a_if.data_in = DW'(96 + i);
      tick();
    end
    a_if.wr_en = 0;
    a_if.rd_en = 1;
    tick();
    a_if.rd_en = 0;
    chk("mr_count", 32'(a_if.count), 5);
    chk("mr_rv", 32'(a_if.rd_valid), 1);
    chk("mr_dout", 32'(a_if.data_out), 32'h60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count", 32'(a_if.count), 0);
    chk("ar_empty", 32'(a_if.empty), 1);
    chk("ar_full", 32'(a_if.full), 0);
    chk("ar_ae", 32'(a_if.almost_empty), 1);
    chk("ar_dout", 32'(a_if.data_out), 0);
    chk("ar_rv", 32'(a_if.rd_valid), 0);
    #1;
    rst_n = 1'b1;
    a_if.wr_en = 1; a_if.data_in = 8'h77;
    tick();
    a_if.wr_en = 0;
    chk("post_count", 32'(a_if.count), 1);
    a_if.rd_en = 1;
    tick();
    a_if.rd_en = 0;
    chk("post_data", 32'(a_if.data_out), 32'h77);
    chk("post_rv", 32'(a_if.rd_valid), 1);
    chk("post_empty", 32'(a_if.empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
